// File: rtl/fft_lane_serializer_if.sv
// ---------------------------------------------------------------------------
// fft_lane_serializer_if
//   Bundles the handshake and data signals of fft_lane_serializer.
//   Upstream side : i_signal_0..3 (4 complex lanes), i_valid, i_last
//   Downstream    : o_data, o_valid, o_last with i_ready backpressure
//   Status        : o_overflow, o_err_len (sticky)
//   Modports      : master = the environment driving inputs / consuming outputs
//                   slave  = the serializer itself
// ---------------------------------------------------------------------------
interface fft_lane_serializer_if #(
  parameter int NB_DATA = 10
);
  logic [2*NB_DATA-1:0] i_signal_0;
  logic [2*NB_DATA-1:0] i_signal_1;
  logic [2*NB_DATA-1:0] i_signal_2;
  logic [2*NB_DATA-1:0] i_signal_3;
  logic                 i_valid;
  logic                 i_last;
  logic                 i_ready;
  logic [2*NB_DATA-1:0] o_data;
  logic                 o_valid;
  logic                 o_last;
  logic                 o_overflow;
  logic                 o_err_len;

  modport master (
    output i_signal_0, i_signal_1, i_signal_2, i_signal_3,
    output i_valid, i_last, i_ready,
    input  o_data, o_valid, o_last, o_overflow, o_err_len
  );

  modport slave (
    input  i_signal_0, i_signal_1, i_signal_2, i_signal_3,
    input  i_valid, i_last, i_ready,
    output o_data, o_valid, o_last, o_overflow, o_err_len
  );
endinterface

// File: rtl/fft_lane_serializer.sv
// ---------------------------------------------------------------------------
// fft_lane_serializer
//   Captures 4-lane parallel complex frames into a two-bank ping-pong buffer
//   and drains them as a single-lane complex stream with valid/ready.
//   The upstream side has no ready: beats arriving while the target bank is
//   still occupied are dropped (o_overflow), together with the rest of that
//   frame.
//   Ports:
//     i_clk   : clock, rising edge
//     i_rst_n : asynchronous active-low reset
//     bus     : fft_lane_serializer_if.slave (lanes, valid/last in,
//               ready in, data/valid/last out, sticky overflow / length error)
//   Parameters:
//     NB_DATA : bits per real/imag part (complex word = 2*NB_DATA)
//     N_BEATS : input beats per full frame (4*N_BEATS samples per frame)
// ---------------------------------------------------------------------------
module fft_lane_serializer #(
  parameter int NB_DATA = 10,
  parameter int N_BEATS = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  fft_lane_serializer_if.slave    bus
);

  localparam int W      = 2*NB_DATA;
  localparam int BEAT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int IDX_W  = BEAT_W + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS-1);

  typedef enum logic [1:0] {
    B_FREE,
    B_FILLING,
    B_FULL,
    B_DRAINING
  } bank_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_e;

  // Storage: bank x beat x lane
  logic [W-1:0] mem [2][N_BEATS][4];
  logic [W-1:0] lanes [4];

  bank_state_e       bank_state   [2];
  bank_state_e       bank_state_n [2];
  // Index of the final beat of the frame held in each bank (length - 1)
  logic [BEAT_W-1:0] bank_last    [2];
  logic [BEAT_W-1:0] bank_last_n  [2];

  logic              wr_bank,   wr_bank_n;
  logic [BEAT_W-1:0] wr_beat,   wr_beat_n;
  logic              dropping,  dropping_n;
  logic [BEAT_W-1:0] drop_beat, drop_beat_n;

  rd_state_e         rd_state,  rd_state_n;
  logic              rd_bank,   rd_bank_n;
  logic [IDX_W-1:0]  rd_idx,    rd_idx_n;

  logic [W-1:0]      data_q,    data_n;
  logic              last_q,    last_n;
  logic              ovf_q,     ovf_n;
  logic              err_q,     err_n;

  logic              wr_en;
  logic              load;
  logic              load_bank;
  logic [IDX_W-1:0]  load_idx;

  assign lanes[0] = bus.i_signal_0;
  assign lanes[1] = bus.i_signal_1;
  assign lanes[2] = bus.i_signal_2;
  assign lanes[3] = bus.i_signal_3;

  assign bus.o_data     = data_q;
  assign bus.o_valid    = (rd_state == RD_STREAM);
  assign bus.o_last     = last_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_err_len  = err_q;

  // Write side and read side both update bank_state_n, but on disjoint
  // states: the writer only touches FREE/FILLING banks, the reader only
  // FULL/DRAINING banks, so at most one of them changes a given bank.
  always_comb begin
    bank_state_n = bank_state;
    bank_last_n  = bank_last;
    wr_bank_n    = wr_bank;
    wr_beat_n    = wr_beat;
    dropping_n   = dropping;
    drop_beat_n  = drop_beat;
    rd_state_n   = rd_state;
    rd_bank_n    = rd_bank;
    rd_idx_n     = rd_idx;
    data_n       = data_q;
    last_n       = last_q;
    ovf_n        = ovf_q;
    err_n        = err_q;
    wr_en        = 1'b0;
    load         = 1'b0;
    load_bank    = rd_bank;
    load_idx     = '0;

    // ---------------- write side ----------------
    if (bus.i_valid) begin
      if (dropping || bank_state[wr_bank] == B_FULL ||
          bank_state[wr_bank] == B_DRAINING) begin
        // Discard this beat and keep discarding until the frame boundary,
        // which follows the same close rule as a stored frame.
        ovf_n = 1'b1;
        if (bus.i_last || drop_beat == LAST_BEAT) begin
          dropping_n  = 1'b0;
          drop_beat_n = '0;
        end else begin
          dropping_n  = 1'b1;
          drop_beat_n = drop_beat + BEAT_W'(1);
        end
      end else begin
        wr_en = 1'b1;
        if (bus.i_last || wr_beat == LAST_BEAT) begin
          bank_state_n[wr_bank] = B_FULL;
          bank_last_n[wr_bank]  = wr_beat;
          wr_bank_n             = ~wr_bank;
          wr_beat_n             = '0;
          // Short frame (early i_last) or full frame missing its i_last
          if (bus.i_last != (wr_beat == LAST_BEAT))
            err_n = 1'b1;
        end else begin
          bank_state_n[wr_bank] = B_FILLING;
          wr_beat_n             = wr_beat + BEAT_W'(1);
        end
      end
    end

    // ---------------- read side ----------------
    unique case (rd_state)
      RD_IDLE: begin
        if (bank_state[rd_bank] == B_FULL) begin
          bank_state_n[rd_bank] = B_DRAINING;
          rd_state_n            = RD_STREAM;
          load                  = 1'b1;
          load_bank             = rd_bank;
          load_idx              = '0;
        end
      end
      RD_STREAM: begin
        if (bus.i_ready) begin
          if (rd_idx == {bank_last[rd_bank], 2'b11}) begin
            bank_state_n[rd_bank] = B_FREE;
            rd_bank_n             = ~rd_bank;
            if (bank_state[~rd_bank] == B_FULL) begin
              // Other frame already waiting: continue without a bubble
              bank_state_n[~rd_bank] = B_DRAINING;
              load                   = 1'b1;
              load_bank              = ~rd_bank;
              load_idx               = '0;
            end else begin
              rd_state_n = RD_IDLE;
              data_n     = '0;
              last_n     = 1'b0;
            end
          end else begin
            load      = 1'b1;
            load_bank = rd_bank;
            load_idx  = rd_idx + IDX_W'(1);
          end
        end
      end
    endcase

    // Sample k lives at beat k/4, lane k%4
    if (load) begin
      rd_idx_n = load_idx;
      data_n   = mem[load_bank][load_idx[IDX_W-1:2]][load_idx[1:0]];
      last_n   = (load_idx == {bank_last[load_bank], 2'b11});
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned b = 0; b < 2; b++) begin
        bank_state[b] <= B_FREE;
        bank_last[b]  <= '0;
      end
      wr_bank   <= 1'b0;
      wr_beat   <= '0;
      dropping  <= 1'b0;
      drop_beat <= '0;
      rd_state  <= RD_IDLE;
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bank_state <= bank_state_n;
      bank_last  <= bank_last_n;
      wr_bank    <= wr_bank_n;
      wr_beat    <= wr_beat_n;
      dropping   <= dropping_n;
      drop_beat  <= drop_beat_n;
      rd_state   <= rd_state_n;
      rd_bank    <= rd_bank_n;
      rd_idx     <= rd_idx_n;
      data_q     <= data_n;
      last_q     <= last_n;
      ovf_q      <= ovf_n;
      err_q      <= err_n;
    end
  end

  // Payload storage needs no reset: bank states gate every read.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int unsigned n = 0; n < 4; n++)
        mem[wr_bank][wr_beat][n] <= lanes[n];
    end
  end

endmodule
